ads127l01_ctrl: RTL and testbench
=================================

Name: ads127l01_ctrl

Overview:
- Sequencer for the ADS127L01 ADC front end in the down-conversion system.
- Runs power-up (pd/start pins), writes and reads back the CONFIG register over an SPI master in the clk domain, then enables conversions.
- Watches the capture block's sample-valid pulses and restarts the ADC on loss of data.
- Sits beside the serial capture block. It owns every ADC control pin except the data-port sck/fsync/din.

Parameters:
- SCK_HALF, 4, clk cycles per SPI sclk half-period (≥2).
- PD_CYCLES, 1024, clk cycles pd held low on power-up/restart.
- SETTLE_CYCLES, 4096, clk cycles after pd release before the first SPI access.
- WDT_CYCLES, 65536, max clk cycles between sample_valid pulses in RUN.
- MAX_RETRY, 3, config write/verify attempts before FAULT.
- CFG_ADDR, 8'h01, ADC register address written and verified.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  master enable; low forces the PWRDN path
- cfg_value  in  8  register value to program; sampled on entry to WREG
- cfg_apply  in  1  one-cycle request to reprogram while in RUN
- sample_valid  in  1  one-cycle pulse per sample from the capture block
- miso  in  1  ADC SPI data out
- pd  out  1  ADC power-down pin, active-low
- start  out  1  ADC start pin
- cs_n  out  1  SPI chip select
- sclk  out  1  SPI clock, idle low
- mosi  out  1  SPI data to ADC
- running  out  1  high in RUN
- fault  out  1  high in FAULT
- readback  out  8  last byte read by RREG
- retry_cnt  out  2  attempts used in the current configuration pass

Behaviour:
- Reset values:
  - pd=0, start=0, cs_n=1, sclk=0, mosi=0.
  - running=0, fault=0, readback=0, retry_cnt=0.
  - State=PWRDN with timer cleared.
- PWRDN:
  - pd=0, start=0.
  - Counts PD_CYCLES only while en=1, then goes to SETTLE.
- SETTLE:
  - pd=1.
  - Counts SETTLE_CYCLES, then goes to WREG.
- WREG:
  - 24-bit SPI frame: opcode 0x40|CFG_ADDR[4:0], byte 0x00, then the latched cfg_value.
  - Goes to RREG when done.
- RREG:
  - 24-bit frame: opcode 0x20|CFG_ADDR[4:0], 0x00, 0x00.
  - Last 8 bits received on miso are stored to readback.
  - Goes to CHECK when done.
- CHECK (one cycle):
  - readback==latched cfg_value → START.
  - Mismatch with retry_cnt<MAX_RETRY-1 → retry_cnt+1, then WREG.
  - Otherwise → FAULT.
- START:
  - start=1.
  - Clears the watchdog, then goes to RUN.
- RUN:
  - running=1.
  - Watchdog resets on sample_valid and increments otherwise.
  - Watchdog reaching WDT_CYCLES-1 → PWRDN, retry_cnt=0.
  - cfg_apply=1 → start=0, retry_cnt=0, then WREG.
- FAULT:
  - fault=1, pd=0, start=0.
  - Exits only on rst, or on en deasserted then reasserted (→ PWRDN).
- SPI frame timing (mode 1):
  - cs_n falls one clk before the first sclk edge.
  - mosi changes on sclk rising edges, MSB first.
  - miso is sampled on sclk falling edges.
  - After the 24th falling edge, cs_n rises, and stays high at least 2·SCK_HALF clk before the next frame.
  - A frame is 48·SCK_HALF + 2·SCK_HALF + 1 clk, counted from frame start.
- en=0 in any state other than PWRDN:
  - Go to PWRDN next cycle.
  - Abort any SPI frame: cs_n=1, sclk=0.
  - running=0.
- Simultaneous events:
  - cfg_apply and watchdog expiry in the same cycle: watchdog wins.
  - cfg_apply outside RUN is ignored.
  - sample_valid outside RUN is ignored.
- Counter widths are $clog2 of their parameter. Counters saturate; they never wrap.

Decomposition:
- Package ads127l01_pkg holds:
  - state enum (PWRDN, SETTLE, WREG, RREG, CHECK, START, RUN, FAULT)
  - opcodes OP_RREG=8'h20, OP_WREG=8'h40
  - SPI_FRAME_BITS=24
- One sub-module, ads127l01_spi_xfer:
  - 24-bit full-duplex shifter and sclk divider.
  - Handshake: go/tx_data[23:0] in, done/rx_data[23:0] out. done is a one-cycle pulse.
  - Has an abort input driven by the en=0 path.

Test Plan:
- Reset, en=1, cfg_value=8'h5A, model echoes written value:
  - pd rises at clk 1024.
  - WREG mosi stream is 0x41,0x00,0x5A.
  - RREG readback=0x5A.
  - start=1, running=1.
- Model returns 0x00 on RREG twice, then 0x5A:
  - Two extra WREG/RREG pairs.
  - retry_cnt ends at 2.
  - RUN is reached.
- Model always returns 0xFF:
  - fault=1 after 3 attempts; pd=0.
  - Toggling en 1→0→1 restarts at PWRDN.
- In RUN, sample_valid pulses every 100 clk, then stops:
  - running holds while pulses arrive.
  - 65536 clk after the last pulse, pd=0 and start=0, and the sequence reruns.
- In RUN, cfg_apply with cfg_value=8'h33:
  - start falls.
  - New frames 0x41,0x00,0x33, then readback=0x33, then start=1.
- en=0 mid-WREG at bit 10:
  - Next cycle cs_n=1, sclk=0, pd=0.
  - No further sclk edges.

Source files
------------

// File: rtl/ads127l01_pkg.sv
// Shared types and constants for the ADS127L01 control sequencer.
package ads127l01_pkg;

   typedef enum logic [2:0] {
      PWRDN, SETTLE, WREG, RREG, CHECK, START, RUN, FAULT
   } state_t;

   localparam logic [7:0] OP_RREG = 8'h20;
   localparam logic [7:0] OP_WREG = 8'h40;
   localparam int SPI_FRAME_BITS = 24;

   // Command frame: opcode with 5-bit register address, a zero count byte, then data.
   function automatic logic [SPI_FRAME_BITS-1:0] reg_frame(input logic [7:0] op,
                                                          input logic [7:0] addr,
                                                          input logic [7:0] data);
      return {op | {3'b000, addr[4:0]}, 8'h00, data};
   endfunction

endpackage

// File: rtl/ads127l01_spi_xfer.sv
// 24-bit mode-1 SPI master: one clk of cs_n lead, 48 sclk half-periods, then a
// cs_n-high guard gap before done pulses; abort drops the frame immediately.
module ads127l01_spi_xfer
   import ads127l01_pkg::*;
#(
   parameter int SCK_HALF = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      go,
   input  logic                      abort,
   input  logic [SPI_FRAME_BITS-1:0] tx_data,
   input  logic                      miso,
   output logic                      done,
   output logic [SPI_FRAME_BITS-1:0] rx_data,
   output logic                      cs_n,
   output logic                      sclk,
   output logic                      mosi
);
   localparam int EDGES = 2 * SPI_FRAME_BITS;
   localparam int DW = $clog2(2 * SCK_HALF);
   localparam int EW = $clog2(EDGES + 1);
   localparam logic [DW-1:0] HALF_LD = DW'(SCK_HALF - 1);
   localparam logic [DW-1:0] GAP_LD = DW'(2 * SCK_HALF - 1);

   typedef enum logic [1:0] {X_IDLE, X_SHIFT, X_GAP} xfer_t;

   xfer_t                     xs;
   logic [DW-1:0]             div;
   logic [EW-1:0]             edg;
   logic [SPI_FRAME_BITS-1:0] sh;

   always_ff @(posedge clk) begin
      done <= 1'b0;
      if (rst || abort) begin
         xs   <= X_IDLE;
         cs_n <= 1'b1;
         sclk <= 1'b0;
         mosi <= 1'b0;
         div  <= '0;
         edg  <= '0;
         if (rst) begin
            sh      <= '0;
            rx_data <= '0;
         end
      end else begin
         case (xs)
            X_IDLE: begin
               if (go) begin
                  cs_n <= 1'b0;
                  sh   <= tx_data;
                  div  <= '0;
                  edg  <= '0;
                  xs   <= X_SHIFT;
               end
            end
            X_SHIFT: begin
               if (div != '0) begin
                  div <= div - 1'b1;
               end else if (edg == EW'(EDGES)) begin
                  // cs_n held one half-period past the last falling edge
                  cs_n <= 1'b1;
                  mosi <= 1'b0;
                  div  <= GAP_LD;
                  xs   <= X_GAP;
               end else begin
                  div <= HALF_LD;
                  edg <= edg + 1'b1;
                  if (!edg[0]) begin
                     sclk <= 1'b1;
                     mosi <= sh[SPI_FRAME_BITS-1];
                     sh   <= {sh[SPI_FRAME_BITS-2:0], 1'b0};
                  end else begin
                     sclk    <= 1'b0;
                     rx_data <= {rx_data[SPI_FRAME_BITS-2:0], miso};
                  end
               end
            end
            X_GAP: begin
               if (div != '0) begin
                  div <= div - 1'b1;
               end else begin
                  done <= 1'b1;
                  xs   <= X_IDLE;
               end
            end
            default: xs <= X_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ads127l01_ctrl.sv
// ADS127L01 sequencer: power-up, CONFIG write/verify with retry, conversion run
// with sample watchdog; en low aborts to power-down from any active state.
module ads127l01_ctrl
   import ads127l01_pkg::*;
#(
   parameter int         SCK_HALF      = 4,
   parameter int         PD_CYCLES     = 1024,
   parameter int         SETTLE_CYCLES = 4096,
   parameter int         WDT_CYCLES    = 65536,
   parameter int         MAX_RETRY     = 3,
   parameter logic [7:0] CFG_ADDR      = 8'h01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] cfg_value,
   input  logic       cfg_apply,
   input  logic       sample_valid,
   input  logic       miso,
   output logic       pd,
   output logic       start,
   output logic       cs_n,
   output logic       sclk,
   output logic       mosi,
   output logic       running,
   output logic       fault,
   output logic [7:0] readback,
   output logic [1:0] retry_cnt
);
   localparam int TW = $clog2(PD_CYCLES > SETTLE_CYCLES ? PD_CYCLES : SETTLE_CYCLES);
   localparam int WW = $clog2(WDT_CYCLES);
   localparam logic [TW-1:0] PD_LAST = TW'(PD_CYCLES - 1);
   localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
   localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);
   localparam logic [1:0] RETRY_LAST = 2'(MAX_RETRY - 1);

   state_t                    state;
   logic [TW-1:0]             timer;
   logic [WW-1:0]             wdt;
   logic [7:0]                cfg_lat;
   logic                      fault_arm;
   logic                      go;
   logic                      done;
   logic [SPI_FRAME_BITS-1:0] tx;
   logic [SPI_FRAME_BITS-1:0] rx;
   logic                      unused_rx;

   assign unused_rx = ^rx[SPI_FRAME_BITS-1:8];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= PWRDN;
         timer     <= '0;
         wdt       <= '0;
         cfg_lat   <= '0;
         fault_arm <= 1'b0;
         go        <= 1'b0;
         tx        <= '0;
         pd        <= 1'b0;
         start     <= 1'b0;
         running   <= 1'b0;
         fault     <= 1'b0;
         readback  <= '0;
         retry_cnt <= '0;
      end else begin
         go <= 1'b0;
         if (!en && state != PWRDN && state != FAULT) begin
            state     <= PWRDN;
            timer     <= '0;
            pd        <= 1'b0;
            start     <= 1'b0;
            running   <= 1'b0;
            retry_cnt <= '0;
         end else begin
            case (state)
               PWRDN: begin
                  pd      <= 1'b0;
                  start   <= 1'b0;
                  running <= 1'b0;
                  fault   <= 1'b0;
                  if (!en) begin
                     timer <= '0;
                  end else if (timer == PD_LAST) begin
                     timer <= '0;
                     pd    <= 1'b1;
                     state <= SETTLE;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               SETTLE: begin
                  if (timer == SETTLE_LAST) begin
                     timer   <= '0;
                     cfg_lat <= cfg_value;
                     tx      <= reg_frame(OP_WREG, CFG_ADDR, cfg_value);
                     go      <= 1'b1;
                     state   <= WREG;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               WREG: begin
                  if (done) begin
                     tx    <= reg_frame(OP_RREG, CFG_ADDR, 8'h00);
                     go    <= 1'b1;
                     state <= RREG;
                  end
               end
               RREG: begin
                  if (done) begin
                     readback <= rx[7:0];
                     state    <= CHECK;
                  end
               end
               CHECK: begin
                  if (readback == cfg_lat) begin
                     start <= 1'b1;
                     state <= START;
                  end else if (retry_cnt < RETRY_LAST) begin
                     retry_cnt <= retry_cnt + 1'b1;
                     cfg_lat   <= cfg_value;
                     tx        <= reg_frame(OP_WREG, CFG_ADDR, cfg_value);
                     go        <= 1'b1;
                     state     <= WREG;
                  end else begin
                     fault     <= 1'b1;
                     fault_arm <= 1'b0;
                     pd        <= 1'b0;
                     start     <= 1'b0;
                     state     <= FAULT;
                  end
               end
               START: begin
                  wdt     <= '0;
                  running <= 1'b1;
                  state   <= RUN;
               end
               RUN: begin
                  // Watchdog expiry outranks a reprogram request in the same cycle
                  if (wdt == WDT_LAST) begin
                     state     <= PWRDN;
                     timer     <= '0;
                     retry_cnt <= '0;
                     pd        <= 1'b0;
                     start     <= 1'b0;
                     running   <= 1'b0;
                  end else if (cfg_apply) begin
                     start     <= 1'b0;
                     running   <= 1'b0;
                     retry_cnt <= '0;
                     cfg_lat   <= cfg_value;
                     tx        <= reg_frame(OP_WREG, CFG_ADDR, cfg_value);
                     go        <= 1'b1;
                     state     <= WREG;
                  end else if (sample_valid) begin
                     wdt <= '0;
                  end else if (wdt != '1) begin
                     wdt <= wdt + 1'b1;
                  end
               end
               FAULT: begin
                  if (!en) begin
                     fault_arm <= 1'b1;
                  end else if (fault_arm) begin
                     fault     <= 1'b0;
                     timer     <= '0;
                     retry_cnt <= '0;
                     state     <= PWRDN;
                  end
               end
               default: state <= PWRDN;
            endcase
         end
      end
   end

   ads127l01_spi_xfer #(
      .SCK_HALF(SCK_HALF)
   ) u_spi (
      .clk     (clk),
      .rst     (rst),
      .go      (go),
      .abort   (~en),
      .tx_data (tx),
      .miso    (miso),
      .done    (done),
      .rx_data (rx),
      .cs_n    (cs_n),
      .sclk    (sclk),
      .mosi    (mosi)
   );

endmodule

// File: tb/tb_ads127l01_ctrl.sv
// Directed bench for ads127l01_ctrl with a behavioural ADC register model on the SPI port.
module tb_ads127l01_ctrl;
   localparam int PD = 1024;
   localparam int ST = 256;
   localparam int WDT = 2048;
   localparam int HALF = 4;
   localparam int S_RUN = 0, S_FAULT = 1, S_PD = 2, S_START = 3, S_CSN = 4;

   logic       clk = 1'b0, rst = 1'b1, en = 1'b1;
   logic       cfg_apply = 1'b0, sample_valid = 1'b0, miso = 1'b0;
   logic [7:0] cfg_value = 8'h5A;
   logic       pd, start, cs_n, sclk, mosi, running, fault;
   logic [7:0] readback;
   logic [1:0] retry_cnt;

   int checks = 0, errors = 0;
   int mode = 0, rreg_base = 0, rreg_count = 0;
   int mon_bits = 0, rise_idx = 0, sclk_edges = 0;
   logic        p_cs = 1'b1, p_sclk = 1'b0;
   logic [23:0] mon_sh = '0;
   logic [7:0]  last_wr = '0, reply = '0;
   logic [23:0] frames[$];

   always #5 clk = ~clk;

   ads127l01_ctrl #(
      .SCK_HALF(HALF), .PD_CYCLES(PD), .SETTLE_CYCLES(ST),
      .WDT_CYCLES(WDT), .MAX_RETRY(3), .CFG_ADDR(8'h01)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .cfg_value(cfg_value), .cfg_apply(cfg_apply),
      .sample_valid(sample_valid), .miso(miso), .pd(pd), .start(start), .cs_n(cs_n),
      .sclk(sclk), .mosi(mosi), .running(running), .fault(fault),
      .readback(readback), .retry_cnt(retry_cnt)
   );

   // ADC model: captures mosi on sclk fall, answers RREG with a byte chosen by mode
   always @(negedge clk) begin
      if (sclk && !p_sclk) sclk_edges++;
      if (!cs_n && p_cs) begin
         mon_bits = 0;
         rise_idx = 0;
      end
      if (!cs_n && sclk && !p_sclk) begin
         if (rise_idx == 16) begin
            if (mon_sh[15:8] == 8'h21) begin
               case (mode)
                  0: reply = last_wr;
                  1: reply = (rreg_count - rreg_base < 2) ? 8'h00 : last_wr;
                  default: reply = 8'hFF;
               endcase
               rreg_count++;
            end else begin
               reply = 8'h00;
            end
         end
         if (rise_idx >= 16) miso = reply[23 - rise_idx];
         else miso = 1'b0;
         rise_idx++;
      end
      if (!cs_n && !sclk && p_sclk) begin
         mon_sh = {mon_sh[22:0], mosi};
         mon_bits++;
      end
      if (cs_n && !p_cs && mon_bits == 24) begin
         frames.push_back(mon_sh);
         if (mon_sh[23:16] == 8'h41) last_wr = mon_sh[7:0];
      end
      p_cs = cs_n;
      p_sclk = sclk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         S_RUN:   return running;
         S_FAULT: return fault;
         S_PD:    return pd;
         S_START: return start;
         default: return cs_n;
      endcase
   endfunction

   function automatic logic [23:0] frame_at(input int i);
      if (i < frames.size()) return frames[i];
      return 'x;
   endfunction

   task automatic wait_bit(input string tag, input int sel, input logic val,
                           input int budget, output int n);
      n = 0;
      while (n < budget) begin
         @(posedge clk);
         #1;
         n++;
         if (sig(sel) === val) return;
      end
      check({tag, "_timeout"}, 32'(sig(sel)), 32'(val));
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n, fb, e;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_pd", pd, 0);
      check("rst_start", start, 0);
      check("rst_csn_sclk_mosi", {cs_n, sclk, mosi}, 3'b100);
      check("rst_run_fault", {running, fault}, 2'b00);
      check("rst_readback", readback, 8'h00);
      check("rst_retry", retry_cnt, 0);

      // Clean power-up with echoing ADC
      fb = frames.size();
      rst = 1'b0;
      wait_bit("pd_rise", S_PD, 1'b1, 3000, n);
      check("pd_rise_clk", n, PD);
      wait_bit("run1", S_RUN, 1'b1, 2000, n);
      check("run1_frames", frames.size() - fb, 2);
      check("run1_wreg", frame_at(fb), 24'h41005A);
      check("run1_rreg", frame_at(fb + 1), 24'h210000);
      check("run1_readback", readback, 8'h5A);
      check("run1_start", start, 1);
      check("run1_retry", retry_cnt, 0);

      // Two bad readbacks, third good
      mode = 1;
      rreg_base = rreg_count;
      fb = frames.size();
      pulse_reset();
      wait_bit("run2", S_RUN, 1'b1, 5000, n);
      check("retry_frames", frames.size() - fb, 6);
      check("retry_wreg3", frame_at(fb + 4), 24'h41005A);
      check("retry_cnt_end", retry_cnt, 2);
      check("retry_readback", readback, 8'h5A);

      // Readback always wrong -> FAULT
      mode = 2;
      fb = frames.size();
      pulse_reset();
      wait_bit("fault", S_FAULT, 1'b1, 5000, n);
      check("fault_frames", frames.size() - fb, 6);
      check("fault_pd", pd, 0);
      check("fault_start_run", {start, running}, 2'b00);
      mode = 0;
      @(negedge clk);
      en = 1'b0;
      repeat (3) @(negedge clk);
      en = 1'b1;
      @(posedge clk);
      #1;
      check("fault_clear", fault, 0);
      check("fault_restart_pd", pd, 0);
      wait_bit("pd_rise2", S_PD, 1'b1, 3000, n);
      check("pd_rise2_clk", n, PD);
      wait_bit("run3", S_RUN, 1'b1, 2000, n);

      // Watchdog: pulses keep RUN alive, then expiry
      for (int i = 0; i < 8; i++) begin
         repeat (99) @(negedge clk);
         sample_valid = 1'b1;
         @(negedge clk);
         sample_valid = 1'b0;
      end
      check("wdt_hold_running", running, 1);
      wait_bit("wdt_expire", S_PD, 1'b0, WDT + 10, n);
      check("wdt_expire_clk", n, WDT);
      check("wdt_start_low", start, 0);
      wait_bit("run4", S_RUN, 1'b1, 3000, n);
      check("wdt_rerun_readback", readback, 8'h5A);

      // Reprogram in RUN with 0x33; later cfg_value changes must not matter
      fb = frames.size();
      @(negedge clk);
      cfg_value = 8'h33;
      cfg_apply = 1'b1;
      @(posedge clk);
      #1;
      check("apply_start_fall", start, 0);
      @(negedge clk);
      cfg_apply = 1'b0;
      cfg_value = 8'h77;
      wait_bit("run5", S_RUN, 1'b1, 1000, n);
      check("apply_wreg", frame_at(fb), 24'h410033);
      check("apply_rreg", frame_at(fb + 1), 24'h210000);
      check("apply_readback", readback, 8'h33);
      check("apply_start", start, 1);

      // cfg_apply in the very cycle the watchdog expires
      repeat (WDT - 1) @(posedge clk);
      @(negedge clk);
      cfg_apply = 1'b1;
      @(posedge clk);
      #1;
      check("wdt_vs_apply_pd", pd, 0);
      check("wdt_vs_apply_run", running, 0);
      @(negedge clk);
      cfg_apply = 1'b0;

      // en drop in the middle of a WREG frame
      wait_bit("frame6", S_CSN, 1'b0, 3000, n);
      n = 0;
      while (rise_idx != 10 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("abort_bit10_reached", rise_idx, 10);
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #1;
      check("abort_csn_sclk", {cs_n, sclk}, 2'b10);
      check("abort_pd", pd, 0);
      e = sclk_edges;
      repeat (100) @(posedge clk);
      check("abort_no_sclk", sclk_edges, e);
      en = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
